// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : shares the data-memory port between CPU (priority) and DMA,
//                with starvation guard, access checks and ack timeout.
// Optional: define DMEM_ARB_PERF_EN to add the perf_* counter outputs.
// Rev 1.0
// ============================================================================
module dmem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int DMEM_BYTES = 6000,
   parameter int MAX_WAIT   = 8,
   parameter int TIMEOUT    = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req_i,
   input  logic          cpu_we_i,
   input  logic [2:0]    cpu_size_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [DW-1:0] cpu_wdata_i,
   output logic [DW-1:0] cpu_rdata_o,
   output logic          cpu_done_o,
   output logic          cpu_err_o,
   output logic          cpu_stall_o,
   input  logic          dma_req_i,
   input  logic          dma_we_i,
   input  logic [2:0]    dma_size_i,
   input  logic [AW-1:0] dma_addr_i,
   input  logic [DW-1:0] dma_wdata_i,
   output logic [DW-1:0] dma_rdata_o,
   output logic          dma_done_o,
   output logic          dma_err_o,
`ifdef DMEM_ARB_PERF_EN
   output logic [31:0]   perf_cpu_stall_cyc_o,
   output logic [31:0]   perf_dma_grants_o,
   output logic [31:0]   perf_errors_o,
`endif
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [2:0]    mem_size_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic          mem_ack_i,
   input  logic [DW-1:0] mem_rdata_i
);

   localparam int WW  = $clog2(MAX_WAIT + 1);
   localparam int TW  = $clog2(TIMEOUT);
   localparam int AW1 = AW + 1;
   localparam logic [WW-1:0]  C_WAIT_SAT  = WW'(MAX_WAIT);
   localparam logic [TW-1:0]  C_TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [AW1-1:0] C_MEM_LIMIT = AW1'(DMEM_BYTES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MEM  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t          state_q;
   logic            owner_dma_q;
   logic [WW-1:0]   wait_cnt_q;
   logic [TW-1:0]   tmo_cnt_q;
   logic            mem_req_q, mem_we_q;
   logic [2:0]      mem_size_q;
   logic [AW-1:0]   mem_addr_q;
   logic [DW-1:0]   mem_wdata_q;
   logic            cpu_done_q, cpu_err_q, dma_done_q, dma_err_q;
   logic [DW-1:0]   cpu_rdata_q, dma_rdata_q;

   logic            grant_dma_d, grant_any_d;
   logic            sel_we_d;
   logic [2:0]      sel_size_d;
   logic [AW-1:0]   sel_addr_d;
   logic [DW-1:0]   sel_wdata_d;
   logic [2:0]      nbytes_d;
   logic [AW1-1:0]  end_addr_d;
   logic            legal_d;

   always_comb begin
      grant_dma_d = dma_req_i & (~cpu_req_i | (wait_cnt_q >= C_WAIT_SAT));
      grant_any_d = grant_dma_d | cpu_req_i;
      sel_we_d    = grant_dma_d ? dma_we_i    : cpu_we_i;
      sel_size_d  = grant_dma_d ? dma_size_i  : cpu_size_i;
      sel_addr_d  = grant_dma_d ? dma_addr_i  : cpu_addr_i;
      sel_wdata_d = grant_dma_d ? dma_wdata_i : cpu_wdata_i;

      case (sel_size_d[1:0])
         2'b00:   nbytes_d = 3'd1;
         2'b01:   nbytes_d = 3'd2;
         2'b10:   nbytes_d = 3'd4;
         default: nbytes_d = 3'd0;
      endcase
      // One bit wider than the address so the end-of-access sum cannot wrap
      end_addr_d = {1'b0, sel_addr_d} + AW1'(nbytes_d);

      legal_d = 1'b1;
      if (sel_size_d == 3'b011 || sel_size_d[2:1] == 2'b11)
         legal_d = 1'b0;
      if (sel_size_d[1:0] == 2'b01 && sel_addr_d[0] != 1'b0)
         legal_d = 1'b0;
      if (sel_size_d == 3'b010 && sel_addr_d[1:0] != 2'b00)
         legal_d = 1'b0;
      if (end_addr_d > C_MEM_LIMIT)
         legal_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         owner_dma_q <= 1'b0;
         wait_cnt_q  <= '0;
         tmo_cnt_q   <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_size_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_done_q  <= 1'b0;
         cpu_err_q   <= 1'b0;
         dma_done_q  <= 1'b0;
         dma_err_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         cpu_done_q <= 1'b0;
         cpu_err_q  <= 1'b0;
         dma_done_q <= 1'b0;
         dma_err_q  <= 1'b0;

         if (state_q == S_IDLE && grant_dma_d)
            wait_cnt_q <= '0;
         else if (dma_req_i && wait_cnt_q < C_WAIT_SAT)
            wait_cnt_q <= wait_cnt_q + 1'b1;

         case (state_q)
            S_IDLE: begin
               if (grant_any_d) begin
                  owner_dma_q <= grant_dma_d;
                  mem_we_q    <= sel_we_d;
                  mem_size_q  <= sel_size_d;
                  mem_addr_q  <= sel_addr_d;
                  mem_wdata_q <= sel_wdata_d;
                  tmo_cnt_q   <= '0;
                  if (legal_d) begin
                     mem_req_q <= 1'b1;
                     state_q   <= S_MEM;
                  end else begin
                     state_q    <= S_RESP;
                     cpu_done_q <= ~grant_dma_d;
                     cpu_err_q  <= ~grant_dma_d;
                     dma_done_q <= grant_dma_d;
                     dma_err_q  <= grant_dma_d;
                  end
               end
            end
            S_MEM: begin
               if (mem_ack_i) begin
                  mem_req_q  <= 1'b0;
                  state_q    <= S_RESP;
                  cpu_done_q <= ~owner_dma_q;
                  dma_done_q <= owner_dma_q;
                  if (!mem_we_q) begin
                     if (owner_dma_q) dma_rdata_q <= mem_rdata_i;
                     else             cpu_rdata_q <= mem_rdata_i;
                  end
               end else if (tmo_cnt_q == C_TMO_LAST) begin
                  mem_req_q  <= 1'b0;
                  state_q    <= S_RESP;
                  cpu_done_q <= ~owner_dma_q;
                  cpu_err_q  <= ~owner_dma_q;
                  dma_done_q <= owner_dma_q;
                  dma_err_q  <= owner_dma_q;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            S_RESP:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cpu_rdata_o = cpu_rdata_q;
   assign cpu_done_o  = cpu_done_q;
   assign cpu_err_o   = cpu_err_q;
   assign cpu_stall_o = cpu_req_i & ~cpu_done_q;
   assign dma_rdata_o = dma_rdata_q;
   assign dma_done_o  = dma_done_q;
   assign dma_err_o   = dma_err_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_size_o  = mem_size_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

`ifdef DMEM_ARB_PERF_EN
   logic [31:0] perf_stall_q, perf_grants_q, perf_errors_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stall_q  <= '0;
         perf_grants_q <= '0;
         perf_errors_q <= '0;
      end else begin
         if (cpu_stall_o)
            perf_stall_q <= perf_stall_q + 32'd1;
         if (state_q == S_IDLE && grant_dma_d)
            perf_grants_q <= perf_grants_q + 32'd1;
         // Error flags are single-cycle, so each errored transaction counts once
         if (cpu_err_q || dma_err_q)
            perf_errors_q <= perf_errors_q + 32'd1;
      end
   end

   assign perf_cpu_stall_cyc_o = perf_stall_q;
   assign perf_dma_grants_o    = perf_grants_q;
   assign perf_errors_o        = perf_errors_q;
`endif

endmodule
`default_nettype wire
